// File: rtl/pwm.sv
// Left-aligned PWM generator with a free-running period counter and a
// shadowed duty value that only changes at period boundaries.
module pwm #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] dutycycle,
    output logic             out
);

    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_q;

    // duty_q tracks the input while in reset and is otherwise captured on the
    // last count of a period, so mid-period input changes never glitch out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            duty_q <= dutycycle;
            out    <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                duty_q <= dutycycle;
            end
            out <= en && (cnt < duty_q);
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Randomised and directed bench for pwm, checked every cycle against a
// period-level model plus literal per-period high-time counts.
module tb_pwm;

    localparam int W = 11;
    localparam int P = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] dutycycle = '0;
    logic         out;

    int      checks = 0;
    int      errors = 0;
    longint  high_total = 0;
    int      tick = 0;
    int      period_duty[$];
    bit      model_valid = 1'b0;
    bit      exp_out = 1'b0;

    pwm #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .dutycycle(dutycycle),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
        end
    endtask

    // Model: tick counts edges since reset release; each period's duty is the
    // input seen on the last edge of the previous period (or during reset).
    task automatic monitor();
        logic         r;
        logic         e;
        logic [W-1:0] d;
        forever begin
            @(posedge clk);
            r = rst;
            e = en;
            d = dutycycle;
            if (!r) begin
                tick = 0;
                period_duty.delete();
                period_duty.push_back(int'(d));
                exp_out = 1'b0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                exp_out = e && ((tick % P) < period_duty[tick / P]);
                if ((tick % P) == P - 1) period_duty.push_back(int'(d));
                tick++;
            end
            #1;
            if (model_valid) begin
                checkOutput("out_cycle", {31'd0, out}, {31'd0, exp_out});
                if (out === 1'b1) high_total++;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input int d, input int n);
        rst = r;
        en = e;
        dutycycle = W'(d);
        repeat (n) @(negedge clk);
    endtask

    task automatic startRun(input int d);
        applyStimulus(1'b0, 1'b1, d, 1);
        checkOutput("reset_out", {31'd0, out}, 32'd0);
        applyStimulus(1'b1, 1'b1, d, 0);
    endtask

    task automatic measure(input int n, output int highs);
        longint h0;
        h0 = high_total;
        repeat (n) @(negedge clk);
        highs = int'(high_total - h0);
    endtask

    initial begin
        int a, b, c;
        int hold;
        fork
            monitor();
        join_none
        @(negedge clk);

        // All-zero duty never raises out.
        startRun(0);
        measure(3 * P, a);
        checkOutput("duty0_3periods", a, 0);

        // Half duty: first edge after release goes high, exactly 1024 per period.
        startRun(1024);
        measure(1, a);
        checkOutput("duty1024_first_edge", {31'd0, out}, 32'd1);
        measure(P - 1, b);
        checkOutput("duty1024_period1", a + b, 1024);
        measure(1024, a);
        measure(1024, b);
        checkOutput("duty1024_p2_first_half", a, 1024);
        checkOutput("duty1024_p2_second_half", b, 0);

        // Extremes.
        startRun(P - 1);
        measure(P, a);
        measure(P, b);
        checkOutput("duty2047_p1", a, P - 1);
        checkOutput("duty2047_p2", b, P - 1);
        startRun(1);
        measure(P, a);
        measure(P, b);
        checkOutput("duty1_p1", a, 1);
        checkOutput("duty1_p2", b, 1);

        // Mid-period duty change only takes effect next period.
        startRun(500);
        measure(200, a);
        applyStimulus(1'b1, 1'b1, 1500, 0);
        measure(P - 200, b);
        checkOutput("glitchfree_current", a + b, 500);
        measure(P, a);
        checkOutput("glitchfree_next", a, 1500);

        // Enable dropped for cnt 100..299, phase preserved.
        startRun(1024);
        measure(100, a);
        applyStimulus(1'b1, 1'b0, 1024, 0);
        measure(200, b);
        applyStimulus(1'b1, 1'b1, 1024, 0);
        measure(P - 300, c);
        checkOutput("en_before_drop", a, 100);
        checkOutput("en_dropped", b, 0);
        checkOutput("en_resumed", c, 724);
        measure(P, a);
        checkOutput("en_next_period", a, 1024);

        // Reset mid-period at cnt 700.
        startRun(1024);
        measure(700, a);
        checkOutput("rst_mid_partial", a, 700);
        applyStimulus(1'b0, 1'b1, 1024, 1);
        checkOutput("rst_mid_out", {31'd0, out}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1024, 0);
        measure(P, a);
        measure(P, b);
        checkOutput("rst_mid_after_p1", a, 1024);
        checkOutput("rst_mid_after_p2", b, 1024);

        // Random mix of duty, enable and occasional reset, checked per cycle.
        for (int i = 0; i < 60; i++) begin
            hold = int'($urandom_range(1, 300));
            case ($urandom_range(0, 9))
                0:       applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, P - 1)), int'($urandom_range(1, 3)));
                1:       applyStimulus(1'b1, 1'b1, 0, hold);
                2:       applyStimulus(1'b1, 1'b1, P - 1, hold);
                3:       applyStimulus(1'b1, 1'b0, int'($urandom_range(0, P - 1)), hold);
                default: applyStimulus(1'b1, 1'b1, int'($urandom_range(0, P - 1)), hold);
            endcase
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
REQ-001 Parameter: WIDTH, default 11, sets the bit width of the duty input and of the period counter; period = 2^WIDTH clock cycles (2048 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 en  input  1  output enable; 1 = PWM waveform driven, 0 = output forced low.
REQ-005 dutycycle  input  WIDTH  high-time per period, in clock cycles (0 .. 2^WIDTH-1).
REQ-006 out  output  1  registered PWM output.

Function
REQ-007 The block SHALL hold a WIDTH-bit free-running counter cnt, incremented by 1 every cycle rst is high, wrapping from 2^WIDTH-1 to 0 with no idle cycle.
- cnt SHALL run regardless of en, so period phase is preserved across en toggles.
REQ-008 The block SHALL hold a WIDTH-bit shadow register duty_q; out SHALL compare against duty_q only, never directly against dutycycle.
REQ-009 duty_q SHALL load dutycycle on the cycle where cnt == 2^WIDTH-1, so a new value takes effect exactly at the next period start (cnt == 0).
- dutycycle changes mid-period SHALL NOT alter the current period (glitch-free update).
REQ-010 While rst is low, duty_q SHALL load dutycycle every cycle, so the first period after reset uses the value present at reset release.
REQ-011 Each cycle with rst high: out <= en AND (cnt < duty_q), using the pre-edge cnt and duty_q values; latency from cnt to out is 1 cycle.
REQ-012 The comparison SHALL be unsigned, full WIDTH bits.
REQ-013 Boundary cases:
- duty_q == 0: out constantly 0.
- duty_q == 2^WIDTH-1: out high 2^WIDTH-1 cycles, low 1 cycle per period.
- 100 % duty is not representable.
REQ-014 en deasserted SHALL drive out to 0 on the next edge; en reasserted mid-period SHALL resume at the current period position, with no counter restart.
REQ-015 Within a period, out SHALL be high for cycles cnt = 0 .. duty_q-1 (as seen one cycle later at out) and low for the remainder: single high pulse, left-aligned.

Reset
REQ-016 On any rising edge with rst low: cnt <= 0 and out <= 0; duty_q <= dutycycle (REQ-010).
REQ-017 Reset asserted mid-period SHALL abort that period immediately; after release the counter restarts at 0 and out follows REQ-011 from the first edge with rst high.
REQ-018 No initial-value dependence: behaviour SHALL be fully defined after one reset cycle.

Verification
REQ-019 WIDTH=11, en=1, dutycycle=0, run 3 periods -> out never high.
REQ-020 WIDTH=11, en=1, dutycycle=1024 from reset -> each 2048-cycle period has exactly 1024 high cycles, contiguous, starting 1 cycle after cnt wraps to 0.
REQ-021 dutycycle=2047 -> exactly 2047 high, 1 low per period; dutycycle=1 -> exactly 1 high, 2047 low per period.
REQ-022 dutycycle changed 500 -> 1500 at cnt=200 -> current period keeps 500 high cycles; next period has 1500.
REQ-023 en dropped at cnt=100 with dutycycle=1024, raised at cnt=300 -> out low from the edge after the drop until the edge after the raise; high again through cnt=1023; period length unchanged.
REQ-024 rst pulled low for 1 cycle at cnt=700 with dutycycle=1024 -> out=0 and cnt=0 on that edge; the following period is a full 2048 cycles with 1024 high.
